// File: rtl/sw_array_ctrl.sv
// sw_array_ctrl: sequencing controller for the Smith-Waterman PE array on bus_clk.
//
// Loads X characters from a 32-bit host stream, steps Y characters through the
// PE chain with per-PE wavefront enables, dumps every PE score to the score FIFO
// after each step, drains the wavefront once Y ends and then raises eof.
//
// Optional build macro: SW_CTRL_MAX_TRACK_EN adds max_score (running maximum of
// every score written) and one trailer word {16'h8000, max} before eof.
//
// Ports:
//   clk, rst             bus_clk, synchronous active-high reset
//   x_data/x_valid       X word (16 chars x 2 bits, char 0 in [1:0]) and valid
//   x_ready              X word accepted this cycle
//   x_loaded             all SEQ_DEPTH X chars held
//   y_char/y_valid       next Y char from the Y shift-FIFO and valid
//   y_ready              Y char consumed when y_valid && y_ready
//   y_done               Y stream closed and Y FIFOs empty
//   pe_x                 X char of PE i at [2i+1:2i]
//   pe_y                 Y char driven into PE 0
//   pe_valid             one-cycle step strobe to all PEs
//   pe_en                per-PE enable (0 holds the PE in reset)
//   score_flat           PE i score at [SCORE_W*(i+1)-1:SCORE_W*i]
//   sc_data/sc_wren      score FIFO write word (zero-extended) and strobe
//   sc_full              score FIFO full
//   eof                  end of results, held until rst
//   busy                 state is neither IDLE nor DONE
//   max_score            (SW_CTRL_MAX_TRACK_EN only) running maximum score
module sw_array_ctrl #(
    parameter int SEQ_DEPTH = 50,
    parameter int SCORE_W   = 16,
    parameter int CNT_W     = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [31:0]                  x_data,
    input  logic                         x_valid,
    output logic                         x_ready,
    output logic                         x_loaded,
    input  logic [1:0]                   y_char,
    input  logic                         y_valid,
    output logic                         y_ready,
    input  logic                         y_done,
    output logic [2*SEQ_DEPTH-1:0]       pe_x,
    output logic [1:0]                   pe_y,
    output logic                         pe_valid,
    output logic [SEQ_DEPTH-1:0]         pe_en,
    input  logic [SCORE_W*SEQ_DEPTH-1:0] score_flat,
    output logic [31:0]                  sc_data,
    output logic                         sc_wren,
    input  logic                         sc_full,
    output logic                         eof,
    output logic                         busy
`ifdef SW_CTRL_MAX_TRACK_EN
    ,
    output logic [SCORE_W-1:0]           max_score
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_Y,
        S_DRAIN,
        S_SETTLE,
        S_DUMP,
        S_DONE,
        S_MAXW
    } state_t;

    localparam logic [CNT_W-1:0]     L_D    = CNT_W'(SEQ_DEPTH);
    localparam logic [CNT_W-1:0]     L_LAST = CNT_W'(SEQ_DEPTH - 1);
    localparam logic [SEQ_DEPTH-1:0] L_ONE  = SEQ_DEPTH'(1);
`ifdef SW_CTRL_MAX_TRACK_EN
    localparam state_t L_END = S_MAXW;
`else
    localparam state_t L_END = S_DONE;
`endif

    state_t                 r_state, w_next;
    logic                   r_x_ready, r_x_loaded, r_pe_valid, r_drain;
    logic [2*SEQ_DEPTH-1:0] r_pe_x, w_new_x;
    logic [1:0]             r_pe_y;
    logic [SEQ_DEPTH-1:0]   r_pe_en;
    logic [CNT_W-1:0]       r_xi, r_step, r_dc, r_di, w_xi_next;
    logic [SCORE_W-1:0]     w_score;
    logic                   w_x_acc, w_x_last, w_y_acc, w_drain_step, w_wr;
`ifdef SW_CTRL_MAX_TRACK_EN
    logic [SCORE_W-1:0]     r_max;
`endif

    assign w_x_acc      = r_state == S_IDLE && r_x_ready && x_valid;
    assign w_xi_next    = r_xi + CNT_W'(16);
    assign w_x_last     = w_x_acc && w_xi_next >= L_D;
    assign w_y_acc      = r_state == S_WAIT_Y && y_valid;
    assign w_drain_step = r_state == S_DRAIN && r_dc < L_D;
    assign w_wr         = r_state == S_DUMP && !sc_full;
    assign w_score      = SCORE_W'(score_flat >> (r_di * SCORE_W));

    // Each PE slot picks its char out of the incoming word when it falls inside
    // the 16-char window starting at xi; slots past SEQ_DEPTH simply do not exist.
    for (genvar g = 0; g < SEQ_DEPTH; g++) begin : g_x
        logic [CNT_W-1:0] w_off;
        assign w_off = CNT_W'(g) - r_xi;
        assign w_new_x[2*g +: 2] = (r_xi <= CNT_W'(g) && w_off < CNT_W'(16)) ?
                                   2'(x_data >> {w_off[3:0], 1'b0}) : r_pe_x[2*g +: 2];
    end

    always_comb begin
        w_next  = r_state;
        y_ready = 1'b0;
        sc_wren = 1'b0;
        sc_data = '0;
        case (r_state)
            S_IDLE:   w_next = w_x_last ? S_WAIT_Y : S_IDLE;
            S_WAIT_Y: begin
                y_ready = 1'b1;
                w_next  = y_valid ? S_SETTLE : y_done ? S_DRAIN : S_WAIT_Y;
            end
            S_DRAIN:  w_next = w_drain_step ? S_SETTLE : L_END;
            S_SETTLE: w_next = S_DUMP;
            S_DUMP: begin
                sc_wren = w_wr;
                sc_data = w_wr ? 32'(w_score) : '0;
                w_next  = (w_wr && r_di == L_LAST) ? (r_drain ? S_DRAIN : S_WAIT_Y) : S_DUMP;
            end
`ifdef SW_CTRL_MAX_TRACK_EN
            S_MAXW: begin
                sc_wren = !sc_full;
                sc_data = sc_full ? '0 : {16'h8000, 16'(r_max)};
                w_next  = sc_full ? S_MAXW : S_DONE;
            end
`endif
            S_DONE:   w_next = S_DONE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_x_ready  <= 1'b0;
            r_x_loaded <= 1'b0;
            r_pe_valid <= 1'b0;
            r_drain    <= 1'b0;
            r_pe_x     <= '0;
            r_pe_y     <= '0;
            r_pe_en    <= '0;
            r_xi       <= '0;
            r_step     <= '0;
            r_dc       <= '0;
            r_di       <= '0;
`ifdef SW_CTRL_MAX_TRACK_EN
            r_max      <= '0;
`endif
        end else begin
            r_state    <= w_next;
            r_x_ready  <= w_next == S_IDLE;
            r_x_loaded <= r_x_loaded | w_x_last;
            r_pe_valid <= w_y_acc | w_drain_step;
            r_di       <= r_state == S_SETTLE ? '0 : w_wr ? r_di + CNT_W'(1) : r_di;
            if (w_x_acc) begin
                r_pe_x <= w_new_x;
                r_xi   <= w_xi_next;
            end
            if (w_y_acc)
                r_pe_y <= y_char;
            // Shifting by step >= SEQ_DEPTH yields zero, so no bit is set once saturated.
            if (w_y_acc || w_drain_step) begin
                r_pe_en <= (r_pe_en & ~(w_drain_step ? L_ONE << r_dc : '0)) | (L_ONE << r_step);
                r_step  <= r_step == L_D ? r_step : r_step + CNT_W'(1);
            end
            if (w_drain_step)
                r_dc <= r_dc + CNT_W'(1);
            if (r_state == S_WAIT_Y && !y_valid && y_done)
                r_drain <= 1'b1;
`ifdef SW_CTRL_MAX_TRACK_EN
            if (w_wr && w_score > r_max)
                r_max <= w_score;
`endif
        end
    end

    assign x_ready  = r_x_ready;
    assign x_loaded = r_x_loaded;
    assign pe_x     = r_pe_x;
    assign pe_y     = r_pe_y;
    assign pe_valid = r_pe_valid;
    assign pe_en    = r_pe_en;
    assign eof      = r_state == S_DONE;
    assign busy     = r_state != S_IDLE && r_state != S_DONE;
`ifdef SW_CTRL_MAX_TRACK_EN
    assign max_score = r_max;
`endif

endmodule

// File: tb/tb_sw_array_ctrl.sv
// tb_sw_array_ctrl: self-checking bench for sw_array_ctrl with SEQ_DEPTH=4.
module tb_sw_array_ctrl;

    localparam int D = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [31:0]   x_data = '0;
    logic          x_valid = 1'b0;
    logic          x_ready, x_loaded, y_ready, pe_valid, sc_wren, eof, busy;
    logic [1:0]    y_char = '0;
    logic          y_valid = 1'b0;
    logic          y_done = 1'b0;
    logic [2*D-1:0] pe_x;
    logic [1:0]    pe_y;
    logic [D-1:0]  pe_en;
    logic [15:0]   sc_arr [D];
    logic [16*D-1:0] score_flat;
    logic [31:0]   sc_data;
    logic          sc_full = 1'b0;
`ifdef SW_CTRL_MAX_TRACK_EN
    logic [15:0]   max_score;
`endif

    int            n_checks = 0;
    int            n_errors = 0;
    int            n_words = 0;
    int            n_extra = 0;
    logic [15:0]   tb_max = '0;
    logic [31:0]   exp_q [$];

    typedef struct {
        logic       is_y;
        logic [1:0] y;
        logic [3:0] en;
    } vec_t;
    vec_t tbl [6];

    assign score_flat = {sc_arr[3], sc_arr[2], sc_arr[1], sc_arr[0]};

    always #5 clk = ~clk;

    sw_array_ctrl #(.SEQ_DEPTH(D), .SCORE_W(16), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .x_data(x_data), .x_valid(x_valid), .x_ready(x_ready), .x_loaded(x_loaded),
        .y_char(y_char), .y_valid(y_valid), .y_ready(y_ready), .y_done(y_done),
        .pe_x(pe_x), .pe_y(pe_y), .pe_valid(pe_valid), .pe_en(pe_en),
        .score_flat(score_flat), .sc_data(sc_data), .sc_wren(sc_wren), .sc_full(sc_full),
        .eof(eof), .busy(busy)
`ifdef SW_CTRL_MAX_TRACK_EN
        , .max_score(max_score)
`endif
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic sel(input int w);
        return w == 0 ? y_ready : w == 1 ? pe_valid : w == 2 ? eof : sc_wren;
    endfunction

    task automatic wait_for(input int w, input string nm);
        int n = 0;
        while (sel(w) !== 1'b1 && n < 300) begin
            tick();
            n++;
        end
        chk(nm, sel(w), 1);
    endtask

    // Scoreboard: every step strobe gets fresh PE scores whose dump is expected next.
    always @(negedge clk) begin
        if (!rst) begin
            if (pe_valid) begin
                for (int i = 0; i < D; i++) begin
                    sc_arr[i] = 16'($urandom_range(1, 30000));
                    exp_q.push_back({16'h0, sc_arr[i]});
                    if (sc_arr[i] > tb_max) tb_max = sc_arr[i];
                end
            end
            if (sc_wren) begin
                if (exp_q.size() > 0) begin
                    chk("sc_data", sc_data, exp_q.pop_front());
                    n_words++;
                end else begin
`ifdef SW_CTRL_MAX_TRACK_EN
                    chk("max_word", sc_data, {16'h8000, tb_max});
                    n_extra++;
`else
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_wren: got data %0h expected no write", sc_data);
`endif
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < D; i++) sc_arr[i] = '0;
        tbl[0] = '{1'b1, 2'd3, 4'b0001};
        tbl[1] = '{1'b1, 2'd1, 4'b0011};
        tbl[2] = '{1'b0, 2'd1, 4'b0110};
        tbl[3] = '{1'b0, 2'd1, 4'b1100};
        tbl[4] = '{1'b0, 2'd1, 4'b1000};
        tbl[5] = '{1'b0, 2'd1, 4'b0000};
        tick();
        tick();
        chk("rst_x_ready", x_ready, 0);
        chk("rst_x_loaded", x_loaded, 0);
        chk("rst_y_ready", y_ready, 0);
        chk("rst_pe_en", pe_en, 0);
        chk("rst_sc_wren", sc_wren, 0);
        chk("rst_busy", busy, 0);
        chk("rst_pe_x", pe_x, 0);
        rst = 1'b0;
        tick();
        chk("idle_x_ready", x_ready, 1);
        x_valid = 1'b1;
        x_data  = 32'h0000_00E4;
        tick();
        x_valid = 1'b0;
        chk("x_loaded", x_loaded, 1);
        chk("x_ready_after_load", x_ready, 0);
        chk("pe_x_load", pe_x, 8'hE4);
        chk("wait_y_busy", busy, 1);
        for (int k = 0; k < 6; k++) begin
            if (tbl[k].is_y) begin
                wait_for(0, "y_ready_timeout");
                y_valid = 1'b1;
                y_char  = tbl[k].y;
                tick();
                y_valid = 1'b0;
                chk("step_pe_valid", pe_valid, 1);
                chk("step_pe_y", pe_y, tbl[k].y);
                chk("settle_no_wren", sc_wren, 0);
            end else begin
                if (!y_done) begin
                    wait_for(0, "y_ready_before_done");
                    y_done = 1'b1;
                end
                wait_for(1, "drain_pe_valid");
            end
            chk("pe_en", pe_en, tbl[k].en);
            if (k == 0) begin
                tick();
                chk("first_wren_latency", sc_wren, 1);
                chk("pe_valid_pulse", pe_valid, 0);
            end
            if (k == 1) begin
                tick();
                tick();
                sc_full = 1'b1;
                repeat (5) begin
                    #2;
                    chk("full_hold_wren", sc_wren, 0);
                    tick();
                end
                sc_full = 1'b0;
            end
            tick();
        end
        wait_for(2, "eof_timeout");
        chk("total_words", n_words, 24);
        chk("queue_empty", exp_q.size(), 0);
        repeat (3) begin
            tick();
            chk("eof_held", eof, 1);
            chk("done_no_wren", sc_wren, 0);
            chk("done_busy", busy, 0);
        end
        chk("pe_x_stable", pe_x, 8'hE4);
        chk("pe_en_final", pe_en, 0);
`ifdef SW_CTRL_MAX_TRACK_EN
        chk("max_score", max_score, tb_max);
        chk("extra_words", n_extra, 1);
`endif
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        x_valid = 1'b1;
        x_data  = 32'hFFFF_FF1B;
        tick();
        x_valid = 1'b0;
        chk("pe_x_reload_clip", pe_x, 8'h1B);
        wait_for(0, "y_ready_run2");
        y_valid = 1'b1;
        y_done  = 1'b1;
        y_char  = 2'd2;
        tick();
        y_valid = 1'b0;
        y_done  = 1'b0;
        chk("y_wins_pe_valid", pe_valid, 1);
        chk("y_wins_pe_y", pe_y, 2);
        chk("run2_pe_en", pe_en, 4'b0001);
        wait_for(3, "run2_dump");
        tick();
        rst = 1'b1;
        exp_q.delete();
        tick();
        rst = 1'b0;
        chk("mid_rst_x_ready", x_ready, 0);
        chk("mid_rst_x_loaded", x_loaded, 0);
        chk("mid_rst_y_ready", y_ready, 0);
        chk("mid_rst_pe_y", pe_y, 0);
        chk("mid_rst_pe_valid", pe_valid, 0);
        chk("mid_rst_pe_en", pe_en, 0);
        chk("mid_rst_sc_wren", sc_wren, 0);
        chk("mid_rst_sc_data", sc_data, 0);
        chk("mid_rst_eof", eof, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_pe_x", pe_x, 0);
        tick();
        chk("mid_rst_idle", x_ready, 1);
        repeat (5) tick();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
